// File: rtl/redmule_pkg.sv
// Shared types and geometry constants for the RedMulE tile sequencer.
// Engine geometry here sets the full tile sizes that the sequencer reports.
package redmule_pkg;

  localparam int unsigned ARRAY_WIDTH  = 12;
  localparam int unsigned ARRAY_HEIGHT = 4;
  localparam int unsigned PIPE_REGS    = 3;
  localparam int unsigned ITER_W       = 16;
  localparam int unsigned LFT_W        = 8;
  localparam int unsigned N_TILE       = (PIPE_REGS + 1) * ARRAY_HEIGHT;
  localparam int unsigned K_TILE       = N_TILE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } tile_seq_state_e;

  typedef struct packed {
    logic [ITER_W-1:0] m;
    logic [ITER_W-1:0] n;
    logic [ITER_W-1:0] k;
    logic [LFT_W-1:0]  rows;
    logic [LFT_W-1:0]  cols;
    logic [LFT_W-1:0]  depth;
    logic              first_k;
    logic              last_k;
    logic              last;
  } tile_desc_t;

endpackage

// File: rtl/redmule_seq_counter.sv
// Wrapping tile-index counter: counts 0..max_i, advancing on en_i.
// wrap_o fires on the advance out of the terminal value and enables the next outer counter.
module redmule_seq_counter #(
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [ITER_W-1:0] max_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              is_last_o,
  output logic              wrap_o
);

  logic [ITER_W-1:0] cnt_q, cnt_d;

  assign is_last_o = (cnt_q == max_i);
  assign wrap_o    = en_i && is_last_o;
  assign cnt_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = is_last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/redmule_tile_sequencer.sv
// Walks the M x N x K tile space of one GEMM job and issues one descriptor per handshake.
// Optional macro REDMULE_SEQ_PERF_EN builds the backpressure stall counter on perf_stall_o.
module redmule_tile_sequencer
  import redmule_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       cfg_x_iters_i,
  input  logic [31:0]       cfg_w_iters_i,
  input  logic [31:0]       cfg_leftovers_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [ITER_W-1:0] tile_m_o,
  output logic [ITER_W-1:0] tile_n_o,
  output logic [ITER_W-1:0] tile_k_o,
  output logic [LFT_W-1:0]  tile_rows_o,
  output logic [LFT_W-1:0]  tile_cols_o,
  output logic [LFT_W-1:0]  tile_depth_o,
  output logic              tile_first_k_o,
  output logic              tile_last_k_o,
  output logic              tile_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       perf_stall_o
);

  localparam logic [LFT_W-1:0] ROWS_FULL  = LFT_W'(ARRAY_WIDTH);
  localparam logic [LFT_W-1:0] COLS_FULL  = LFT_W'(N_TILE);
  localparam logic [LFT_W-1:0] DEPTH_FULL = LFT_W'(K_TILE);

  tile_seq_state_e   state_q;
  logic              valid_q, busy_q, done_q, err_q;
  logic [ITER_W-1:0] m_max_q, n_max_q, k_max_q;
  logic [LFT_W-1:0]  m_lft_q, n_lft_q, k_lft_q;

  logic [ITER_W-1:0] cfg_m, cfg_kx, cfg_kw, cfg_n;
  logic [LFT_W-1:0]  cfg_m_lft, cfg_kx_lft, cfg_kw_lft, cfg_n_lft;
  logic              cfg_mismatch, cfg_empty;
  logic              start_acc, hs, cnt_clr;

  logic [ITER_W-1:0] m_cnt, n_cnt, k_cnt;
  logic              m_last, n_last, k_last;
  logic              m_wrap, n_wrap, k_wrap;
  tile_desc_t        desc;

  assign cfg_m      = cfg_x_iters_i[31:16];
  assign cfg_kx     = cfg_x_iters_i[15:0];
  assign cfg_kw     = cfg_w_iters_i[31:16];
  assign cfg_n      = cfg_w_iters_i[15:0];
  assign cfg_m_lft  = cfg_leftovers_i[31:24];
  assign cfg_kx_lft = cfg_leftovers_i[23:16];
  assign cfg_kw_lft = cfg_leftovers_i[15:8];
  assign cfg_n_lft  = cfg_leftovers_i[7:0];

  assign cfg_mismatch = (cfg_kx != cfg_kw) || (cfg_kx_lft != cfg_kw_lft);
  assign cfg_empty    = (cfg_m == '0) || (cfg_n == '0) || (cfg_kx == '0);

  assign start_acc = (state_q == IDLE) && start_i && !clear_i;
  assign hs        = valid_q && tile_ready_i;
  assign cnt_clr   = clear_i || start_acc;

  // Counters hold terminal values (count-1) so compares stay within ITER_W bits
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      m_max_q <= cfg_m - 1'b1;
      n_max_q <= cfg_n - 1'b1;
      k_max_q <= cfg_kx - 1'b1;
      m_lft_q <= cfg_m_lft;
      n_lft_q <= cfg_n_lft;
      k_lft_q <= cfg_kx_lft;
    end
  end

  redmule_seq_counter #(.ITER_W(ITER_W)) i_k_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(hs), .max_i(k_max_q),
    .cnt_o(k_cnt), .is_last_o(k_last), .wrap_o(k_wrap)
  );

  redmule_seq_counter #(.ITER_W(ITER_W)) i_n_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(k_wrap), .max_i(n_max_q),
    .cnt_o(n_cnt), .is_last_o(n_last), .wrap_o(n_wrap)
  );

  redmule_seq_counter #(.ITER_W(ITER_W)) i_m_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(n_wrap), .max_i(m_max_q),
    .cnt_o(m_cnt), .is_last_o(m_last), .wrap_o(m_wrap)
  );

  // Descriptor is forced to zero whenever no tile is being offered
  always_comb begin
    desc = '0;
    if (valid_q) begin
      desc.m       = m_cnt;
      desc.n       = n_cnt;
      desc.k       = k_cnt;
      desc.rows    = (m_last && (m_lft_q != '0)) ? m_lft_q : ROWS_FULL;
      desc.cols    = (n_last && (n_lft_q != '0)) ? n_lft_q : COLS_FULL;
      desc.depth   = (k_last && (k_lft_q != '0)) ? k_lft_q : DEPTH_FULL;
      desc.first_k = (k_cnt == '0);
      desc.last_k  = k_last;
      desc.last    = m_last && n_last && k_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (cfg_mismatch || cfg_empty) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= cfg_mismatch;
            end else begin
              state_q <= ISSUE;
              valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // The outermost wrap coincides with acceptance of the final descriptor
          if (m_wrap) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REDMULE_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || start_acc) begin
      stall_q <= '0;
    end else if (valid_q && !tile_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

  assign tile_valid_o   = valid_q;
  assign tile_m_o       = desc.m;
  assign tile_n_o       = desc.n;
  assign tile_k_o       = desc.k;
  assign tile_rows_o    = desc.rows;
  assign tile_cols_o    = desc.cols;
  assign tile_depth_o   = desc.depth;
  assign tile_first_k_o = desc.first_k;
  assign tile_last_k_o  = desc.last_k;
  assign tile_last_o    = desc.last;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
